// File: rtl/mem_stage_ctrl.sv
// MEM-stage sequencer: runs one req/ack data-memory access per memory op, stalls the pipe meanwhile, aborts on timeout.
// Optional MEM_STAGE_PERF_EN adds a saturating stall_cycles counter output.
module mem_stage_ctrl #(
  parameter int DATA_W  = 21,
  parameter int RR_W    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead_in,
  input  logic              MemWrite_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] RD3_in,
  input  logic [RR_W-1:0]   RR3_in,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              err_clr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              stall,
  output logic [DATA_W-1:0] load_data,
  output logic [RR_W-1:0]   load_rr,
  output logic              load_valid,
  output logic              mem_err,
  output logic [1:0]        state_dbg
`ifdef MEM_STAGE_PERF_EN
  ,
  output logic [15:0]       stall_cycles
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ABORT  = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [RR_W-1:0]     rr_q, rr_d;
  logic [DATA_W-1:0]   load_data_q, load_data_d;
  logic [RR_W-1:0]     load_rr_q, load_rr_d;
  logic                load_valid_q, load_valid_d;
  logic                err_q, err_d;
  logic                stall_c;
  logic                op;

  assign op = MemRead_in | MemWrite_in;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    rr_d         = rr_q;
    load_data_d  = load_data_q;
    load_rr_d    = load_rr_q;
    load_valid_d = 1'b0;
    err_d        = err_clr ? 1'b0 : err_q;
    stall_c      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (op) begin
          stall_c = 1'b1;
          addr_d  = alu_in;
          wdata_d = RD3_in;
          rr_d    = RR3_in;
          // Write wins when both request bits are set.
          we_d    = MemWrite_in;
          cnt_d   = 8'd0;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        // Releasing stall on the ack edge lets EX/MEM advance as the access retires.
        stall_c = ~mem_ack;
        if (mem_ack) begin
          if (!we_q) begin
            load_data_d  = mem_rdata;
            load_rr_d    = rr_q;
            load_valid_d = 1'b1;
          end
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == CNT_LAST) begin
            state_d = S_ABORT;
          end
        end
      end
      S_ABORT: begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      rr_q         <= '0;
      load_data_q  <= '0;
      load_rr_q    <= '0;
      load_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      rr_q         <= rr_d;
      load_data_q  <= load_data_d;
      load_rr_q    <= load_rr_d;
      load_valid_q <= load_valid_d;
      err_q        <= err_d;
    end
  end

  // Stall is forced low while reset is held, even with an op pending.
  assign stall      = stall_c & rst;
  assign mem_req    = (state_q == S_ACCESS);
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign load_data  = load_data_q;
  assign load_rr    = load_rr_q;
  assign load_valid = load_valid_q;
  assign mem_err    = err_q;
  assign state_dbg  = state_q;

`ifdef MEM_STAGE_PERF_EN
  logic [15:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (err_clr) begin
      stall_cycles_d = 16'd0;
    end else if (stall && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_q <= 16'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: transaction-level reference model checked every cycle, plus directed literal checks.
module tb_mem_stage_ctrl;
  localparam int DATA_W  = 21;
  localparam int RR_W    = 4;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              MemRead_in = 1'b0, MemWrite_in = 1'b0;
  logic [DATA_W-1:0] alu_in = '0, RD3_in = '0, mem_rdata = '0;
  logic [RR_W-1:0]   RR3_in = '0;
  logic              mem_ack = 1'b0, err_clr = 1'b0;
  logic              mem_req, mem_we, stall, load_valid, mem_err;
  logic [DATA_W-1:0] mem_addr, mem_wdata, load_data;
  logic [RR_W-1:0]   load_rr;
  logic [1:0]        state_dbg;

  int n_vec = 0;
  int n_err = 0;

  mem_stage_ctrl #(.DATA_W(DATA_W), .RR_W(RR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .alu_in(alu_in), .RD3_in(RD3_in), .RR3_in(RR3_in), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .err_clr(err_clr), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .stall(stall), .load_data(load_data),
    .load_rr(load_rr), .load_valid(load_valid), .mem_err(mem_err), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: one outstanding transaction, counted in waited cycles
  bit                m_in_txn, m_abort, m_we, m_err, m_lv;
  int                m_waited;
  logic [DATA_W-1:0] m_addr, m_wdata, m_ld_data;
  logic [RR_W-1:0]   m_rr, m_ld_rr;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_in_txn = 0; m_abort = 0; m_we = 0; m_err = 0; m_lv = 0; m_waited = 0;
      m_addr = '0; m_wdata = '0; m_ld_data = '0; m_rr = '0; m_ld_rr = '0;
    end else begin : model_step
      bit was_txn, was_abort;
      was_txn   = m_in_txn;
      was_abort = m_abort;
      m_lv      = 0;
      if (was_abort) m_err = 1;
      else if (err_clr) m_err = 0;
      m_abort = 0;
      if (was_txn) begin
        if (mem_ack) begin
          if (!m_we) begin
            m_ld_data = mem_rdata;
            m_ld_rr   = m_rr;
            m_lv      = 1;
          end
          m_in_txn = 0;
        end else begin
          m_waited++;
          if (m_waited == TIMEOUT) begin
            m_in_txn = 0;
            m_abort  = 1;
          end
        end
      end else if (!was_abort && (MemRead_in || MemWrite_in)) begin
        m_addr   = alu_in;
        m_wdata  = RD3_in;
        m_rr     = RR3_in;
        m_we     = MemWrite_in;
        m_waited = 0;
        m_in_txn = 1;
      end
    end
  end

  // scoreboard-side monitor counters used by directed checks
  int stall_cnt, req_cnt, lv_cnt, req_starts;
  logic prev_req = 1'b0;
  logic [DATA_W-1:0] last_addr, last_wdata;
  logic last_we;

  // compare process: every negedge, outputs against the model
  always @(negedge clk) begin : compare
    logic exp_stall;
    if (!rst) exp_stall = 1'b0;
    else if (m_in_txn) exp_stall = !mem_ack;
    else if (m_abort) exp_stall = 1'b0;
    else exp_stall = MemRead_in | MemWrite_in;
    chk("stall", stall, exp_stall);
    chk("mem_req", mem_req, m_in_txn);
    chk("mem_we", mem_we, m_we);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("load_valid", load_valid, m_lv);
    chk("load_data", load_data, m_ld_data);
    chk("load_rr", load_rr, m_ld_rr);
    chk("mem_err", mem_err, m_err);
    if (rst) begin
      if (stall) stall_cnt++;
      if (load_valid) lv_cnt++;
      if (mem_req) begin
        req_cnt++;
        if (!prev_req) req_starts++;
        last_addr  = mem_addr;
        last_wdata = mem_wdata;
        last_we    = mem_we;
      end
    end
    prev_req = mem_req;
  end

  task automatic clr_cnt();
    stall_cnt = 0; req_cnt = 0; lv_cnt = 0; req_starts = 0;
  endtask

  // driver: called at posedge+1 in IDLE; ack arrives on ACCESS cycle ack_delay+1
  task automatic do_txn(input bit rd, input bit wr, input int addr, input int wd,
                        input int rr, input int ack_delay, input int rdata);
    MemRead_in  = rd;
    MemWrite_in = wr;
    alu_in      = DATA_W'(addr);
    RD3_in      = DATA_W'(wd);
    RR3_in      = RR_W'(rr);
    mem_ack     = 1'b0;
    @(posedge clk); #1;
    MemRead_in  = 1'b0;
    MemWrite_in = 1'b0;
    repeat (ack_delay) begin
      @(posedge clk); #1;
    end
    mem_ack   = 1'b1;
    mem_rdata = DATA_W'(rdata);
    @(posedge clk); #1;
    mem_ack = 1'b0;
  endtask

  initial begin
    #23 rst = 1'b1;
    @(posedge clk); #1;
    chk("reset_req", mem_req, 1'b0);
    chk("reset_stall", stall, 1'b0);
    chk("reset_load_data", load_data, 32'd0);
    chk("reset_state", state_dbg, 32'd0);

    // load, immediate ack
    clr_cnt();
    do_txn(1, 0, 100, 0, 5, 0, 777);
    @(posedge clk); #1;
    chk("ld_stall_cycles", stall_cnt, 32'd1);
    chk("ld_req_cycles", req_cnt, 32'd1);
    chk("ld_addr", last_addr, 32'd100);
    chk("ld_we", last_we, 32'd0);
    chk("ld_pulses", lv_cnt, 32'd1);
    chk("ld_data", load_data, 32'd777);
    chk("ld_rr", load_rr, 32'd5);

    // store with 3 wait cycles
    clr_cnt();
    do_txn(0, 1, 300, 400, 0, 3, 0);
    @(posedge clk); #1;
    chk("st_req_cycles", req_cnt, 32'd4);
    chk("st_stall_cycles", stall_cnt, 32'd4);
    chk("st_we", last_we, 32'd1);
    chk("st_wdata", last_wdata, 32'd400);
    chk("st_addr", last_addr, 32'd300);
    chk("st_pulses", lv_cnt, 32'd0);
    chk("st_hold_data", load_data, 32'd777);

    // timeout
    clr_cnt();
    MemRead_in = 1'b1; alu_in = 21'd50;
    @(posedge clk); #1;
    MemRead_in = 1'b0;
    repeat (TIMEOUT) begin
      @(posedge clk); #1;
    end
    chk("to_req_cycles", req_cnt, 32'd15);
    chk("to_abort_req", mem_req, 32'd0);
    chk("to_abort_stall", stall, 32'd0);
    @(posedge clk); #1;
    chk("to_err_set", mem_err, 32'd1);
    chk("to_pulses", lv_cnt, 32'd0);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("to_err_clr", mem_err, 32'd0);

    // simultaneous read/write request
    clr_cnt();
    do_txn(1, 1, 8, 9, 2, 1, 55);
    @(posedge clk); #1;
    chk("both_we", last_we, 32'd1);
    chk("both_addr", last_addr, 32'd8);
    chk("both_pulses", lv_cnt, 32'd0);

    // back-to-back load then store
    clr_cnt();
    do_txn(1, 0, 10, 0, 3, 0, 11);
    do_txn(0, 1, 20, 99, 0, 0, 0);
    @(posedge clk); #1;
    chk("b2b_starts", req_starts, 32'd2);
    chk("b2b_stall_cycles", stall_cnt, 32'd2);
    chk("b2b_pulses", lv_cnt, 32'd1);
    chk("b2b_load_data", load_data, 32'd11);
    chk("b2b_last_addr", last_addr, 32'd20);

    // async reset mid-ACCESS
    MemRead_in = 1'b1; alu_in = 21'd66; RR3_in = 4'd7;
    @(posedge clk); #1;
    MemRead_in = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_req", mem_req, 32'd0);
    chk("rst_mid_stall", stall, 32'd0);
    chk("rst_mid_lv", load_valid, 32'd0);
    #9 rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_rel_state", state_dbg, 32'd0);
    chk("rst_rel_req", mem_req, 32'd0);

    // randomized traffic; second half uses a sparse ack to provoke timeouts
    for (int i = 0; i < 2000; i++) begin
      int ack_pct;
      ack_pct     = (i < 1000) ? 35 : 6;
      MemRead_in  = ($urandom_range(0, 99) < 30);
      MemWrite_in = ($urandom_range(0, 99) < 20);
      alu_in      = DATA_W'($urandom);
      RD3_in      = DATA_W'($urandom);
      RR3_in      = RR_W'($urandom);
      mem_ack     = ($urandom_range(0, 99) < ack_pct);
      mem_rdata   = DATA_W'($urandom);
      err_clr     = ($urandom_range(0, 99) < 5);
      @(posedge clk); #1;
    end

    MemRead_in = 1'b0; MemWrite_in = 1'b0; mem_ack = 1'b0; err_clr = 1'b0;
    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
